// File: rtl/mux_scheduler.sv
// Round-robin scheduler sharing one DATA_W-bit mux/demux channel among 4 requesters.
// Optional SCHED_PARK_EN: park sel at 0 and restart arbitration from requester 0 when idle.
module mux_scheduler #(
    parameter int DATA_W = 8,
    parameter int HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   req_data,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic                  bus_valid,
    output logic [DATA_W-1:0]     bus_data,
    output logic                  busy
);

    localparam logic [7:0] HOLD_L = 8'(HOLD);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] dwell;

    logic       found;
    logic [1:0] pick;
    logic [1:0] idx;

    // Scan downward so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        found = |req;
        pick  = ptr;
        idx   = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            sel       <= 2'd0;
            bus_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= 2'd0;
            dwell     <= 8'd0;
        end else begin
            case (state)
                IDLE, RELEASE: begin
                    if (found) begin
                        state     <= GRANT;
                        gnt       <= 4'b0001 << pick;
                        sel       <= pick;
                        bus_valid <= 1'b1;
                        busy      <= 1'b1;
                        dwell     <= 8'd1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef SCHED_PARK_EN
                        sel   <= 2'd0;
                        ptr   <= 2'd0;
`endif
                    end
                end
                GRANT: begin
                    if (req[sel] && (dwell < HOLD_L)) begin
                        dwell <= dwell + 8'd1;
                    end else begin
                        // The dead RELEASE cycle keeps demux outputs from overlapping.
                        state     <= RELEASE;
                        gnt       <= 4'b0000;
                        bus_valid <= 1'b0;
                        ptr       <= sel + 2'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 4'b0000;
                    bus_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus_data = bus_valid ? req_data[sel*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_mux_scheduler.sv
// Self-checking bench for mux_scheduler (DATA_W=8, HOLD=4): vector table plus
// hand-written corner sequences, expected outputs queued and popped after each edge.
module tb_mux_scheduler;

    localparam int DATA_W = 8;

`ifdef SCHED_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       busy;
        logic [7:0] data;
    } obs_t;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        obs_t       exp;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [3:0]          req;
    logic [4*DATA_W-1:0] reqData;
    logic [3:0]          gnt;
    logic [1:0]          sel;
    logic                busValid;
    logic [DATA_W-1:0]   busData;
    logic                busy;

    obs_t       expQ[$];
    vec_t       vecs[$];
    logic [7:0] lanes[4];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    mux_scheduler #(.DATA_W(DATA_W), .HOLD(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (reqData),
        .gnt      (gnt),
        .sel      (sel),
        .bus_valid(busValid),
        .bus_data (busData),
        .busy     (busy)
    );

    function automatic obs_t mkObs(input logic [3:0] g, input logic [1:0] s,
                                   input logic v, input logic b, input logic [7:0] d);
        obs_t o;
        o.gnt   = g;
        o.sel   = s;
        o.valid = v;
        o.busy  = b;
        o.data  = d;
        return o;
    endfunction

    // Pops the oldest expectation and compares it against what the DUT shows now.
    task automatic checkOutput(input string name);
        obs_t e;
        obs_t a;
        e = expQ.pop_front();
        a = '{gnt: gnt, sel: sel, valid: busValid, busy: busy, data: busData};
        total++;
        if (a !== e) begin
            bad++;
            $display("[TB] FAIL %s: got gnt=%b sel=%0d valid=%b busy=%b data=%h, want gnt=%b sel=%0d valid=%b busy=%b data=%h",
                     name, a.gnt, a.sel, a.valid, a.busy, a.data,
                     e.gnt, e.sel, e.valid, e.busy, e.data);
        end
    endtask

    // Drives one cycle of inputs, queues the post-edge expectation, then samples after the edge.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input obs_t e, input string name);
        reset = r;
        req   = rq;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    initial begin
        lanes[0] = 8'h11;
        lanes[1] = 8'h22;
        lanes[2] = 8'hA5;
        lanes[3] = 8'h44;
        reqData  = {lanes[3], lanes[2], lanes[1], lanes[0]};
        reset    = 1'b1;
        req      = 4'b0000;

        // Reset, then a lone requester 2: four granted cycles, one dead cycle, re-grant.
        vecs.push_back('{1'b1, 4'b0000, mkObs(4'b0000, 2'd0, 1'b0, 1'b0, 8'h00)});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b0, 4'b0100, mkObs(4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5)});
        vecs.push_back('{1'b0, 4'b0100, mkObs(4'b0000, 2'd2, 1'b0, 1'b1, 8'h00)});
        vecs.push_back('{1'b0, 4'b0100, mkObs(4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5)});
        // Drop request: release, then idle where sel parks or holds.
        vecs.push_back('{1'b0, 4'b0000, mkObs(4'b0000, 2'd2, 1'b0, 1'b1, 8'h00)});
        vecs.push_back('{1'b0, 4'b0000, mkObs(4'b0000, PARK ? 2'd0 : 2'd2, 1'b0, 1'b0, 8'h00)});
        vecs.push_back('{1'b0, 4'b1001, PARK ? mkObs(4'b0001, 2'd0, 1'b1, 1'b1, 8'h11)
                                             : mkObs(4'b1000, 2'd3, 1'b1, 1'b1, 8'h44)});
        // Reset asserted while a grant is active.
        vecs.push_back('{1'b1, 4'b1001, mkObs(4'b0000, 2'd0, 1'b0, 1'b0, 8'h00)});
        // All requesting: rotate 0,1,2,3 with one dead cycle between grants, then wrap to 0.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++)
                vecs.push_back('{1'b0, 4'b1111,
                                 mkObs(4'(1 << i), 2'(i), 1'b1, 1'b1, lanes[i])});
            vecs.push_back('{1'b0, 4'b1111, mkObs(4'b0000, 2'(i), 1'b0, 1'b1, 8'h00)});
        end
        vecs.push_back('{1'b0, 4'b1111, mkObs(4'b0001, 2'd0, 1'b1, 1'b1, 8'h11)});
        vecs.push_back('{1'b0, 4'b0000, mkObs(4'b0000, 2'd0, 1'b0, 1'b1, 8'h00)});
        vecs.push_back('{1'b0, 4'b0000, mkObs(4'b0000, 2'd0, 1'b0, 1'b0, 8'h00)});

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].exp, $sformatf("vec%0d", i));

        // Early release after two granted cycles.
        applyStimulus(1'b0, 4'b0010, mkObs(4'b0010, 2'd1, 1'b1, 1'b1, 8'h22), "early_g1");
        applyStimulus(1'b0, 4'b0010, mkObs(4'b0010, 2'd1, 1'b1, 1'b1, 8'h22), "early_g2");
        applyStimulus(1'b0, 4'b0000, mkObs(4'b0000, 2'd1, 1'b0, 1'b1, 8'h00), "early_rel");
        applyStimulus(1'b0, 4'b0000, mkObs(4'b0000, PARK ? 2'd0 : 2'd1, 1'b0, 1'b0, 8'h00), "early_idle");

        // Late arrival of requester 3 must wait for requester 0's full grant.
        applyStimulus(1'b0, 4'b0001, mkObs(4'b0001, 2'd0, 1'b1, 1'b1, 8'h11), "late_g1");
        for (int i = 2; i <= 4; i++)
            applyStimulus(1'b0, 4'b1001, mkObs(4'b0001, 2'd0, 1'b1, 1'b1, 8'h11),
                          $sformatf("late_g%0d", i));
        applyStimulus(1'b0, 4'b1001, mkObs(4'b0000, 2'd0, 1'b0, 1'b1, 8'h00), "late_rel");
        applyStimulus(1'b0, 4'b1001, mkObs(4'b1000, 2'd3, 1'b1, 1'b1, 8'h44), "late_gnt3");
        // Lane data change mid-grant shows up on the bus combinationally.
        reqData[31:24] = 8'h5C;
        applyStimulus(1'b0, 4'b1000, mkObs(4'b1000, 2'd3, 1'b1, 1'b1, 8'h5C), "late_data");
        applyStimulus(1'b0, 4'b0000, mkObs(4'b0000, 2'd3, 1'b0, 1'b1, 8'h00), "late_rel3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
